verlet_node_q: RTL
==================

# verlet_node_q

Parametrised fixed-point Verlet integrator node for the rope/cloth simulator. Each instance holds one particle's current and previous position in signed Q(WIDTH-FRAC).FRAC format. It advances by one Verlet step per handshake and accepts externally computed constraint corrections between steps. It sits in the node array under the simulation sequencer, which issues step and constraint commands.

## Interface
- WIDTH, 32, position word width (signed)
- FRAC, 16, fractional bits
- NODE_ID, 1, node index; sets initial y
- BASE_X, 200, initial x, integer units
- SPACING, 10, initial y per node index, integer units
- GRAVITY, 32'h0000_4CCD, per-step y acceleration in raw Q format (≈0.3)
- DAMP_SHIFT, 0, velocity damping factor 1-2^-DAMP_SHIFT; 0 = no damping
- PINNED, 0, 1 = node never moves
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- step_valid  in  1  request one integration step
- step_ready  out  1  step accepted on clk edge when both high
- cons_valid  in  1  constraint position valid
- cons_ready  out  1  constraint accepted on clk edge when both high
- cons_x, cons_y  in  WIDTH  corrected position, Q format
- x_pos, y_pos  out  WIDTH  current position
- step_done  out  1  one-cycle pulse, step committed
- step_count  out  16  completed steps, wraps
- busy  out  1  FSM not in IDLE

## Operation
- Reset values: x=px=BASE_X<<FRAC; y=py=(SPACING*NODE_ID)<<FRAC; FSM IDLE; step_done=0; step_count=0.
- FSM: IDLE -> VEL on step accept; VEL -> POS unconditionally; POS -> IDLE unconditionally.
- VEL: vx=x-px, vy=y-py computed in WIDTH+1 bits. If DAMP_SHIFT>0: v=v-(v>>>DAMP_SHIFT), arithmetic shift. Saturate to WIDTH and register.
- POS: px<=x, py<=y, x<=sat(x+vx), y<=sat(y+vy+GRAVITY). Sums use WIDTH+2 bits, saturate to [-2^(WIDTH-1), 2^(WIDTH-1)-1]. y increases downward.
- Constraint, IDLE only: x<=cons_x, y<=cons_y; px/py unchanged, so the correction feeds into the next velocity.
- cons_ready = (state==IDLE). step_ready = (state==IDLE) && !cons_valid. A constraint therefore wins over a simultaneous step; the step waits one cycle.
- PINNED=1: both handshakes still complete and step_done/step_count behave normally. x, y, px, py never change.
- step_count increments at the POS->IDLE edge, wraps 0xFFFF->0.
- Async reset at any state: immediate return to reset values. A step in progress is discarded with no step_done.

## Timing
- Step accepted at edge T: VEL registers at T+1; positions update and step_done is set at T+2. step_done is high for the cycle after T+2; step_ready is high again in that same cycle.
- Maximum throughput is one step per 3 cycles.
- Constraint latency: the accept edge updates x_pos/y_pos directly, one cycle.
- Outputs are registered; no combinational path from inputs to x_pos/y_pos.
- step_ready/cons_ready depend combinationally on state and cons_valid only.

## Structure
- Shared package verlet_pkg: state enum {IDLE, VEL, POS}, Q-format constants (FRAC, ONE), a to_q(int) helper, and a generic saturate function.
- One sub-module: fxp_sat_add, a parametrised signed 3-input saturating adder used for x and y in POS.

## Test plan
- Reset, defaults: x_pos=0x00C8_0000, y_pos=0x000A_0000, step_ready=1, busy=0, step_count=0.
- Two steps from rest: after step 1, y_pos=0x000A_4CCD, x unchanged, step_done pulses 3 cycles after accept. After step 2, y_pos=0x000A_E667, step_count=2.
- Constraint then step: cons_x=0x00CA_0000 accepted, x_pos=0x00CA_0000 next cycle. The following step gives x_pos=0x00CC_0000. With DAMP_SHIFT=1 it gives 0x00CB_0000.
- Saturation: constrain y to 0x7FFF_F000 from py=0x000A_0000, then step -> y_pos=0x7FFF_FFFF, no wrap.
- Simultaneous cons_valid and step_valid in IDLE: constraint accepted with step_ready=0, step accepted the next cycle. With PINNED=1 the same sequence leaves positions at reset values while step_count increments.
- Async reset asserted mid-POS: x_pos/y_pos return to reset values without a clock edge, step_done stays 0, and FSM is IDLE after release.

Source files
------------

// File: rtl/verlet_pkg.sv
// Shared types and Q-format helpers for the Verlet node array.
package verlet_pkg;

  typedef enum logic [1:0] {IDLE, VEL, POS} state_t;

  localparam int unsigned      Q_FRAC = 16;
  localparam logic signed [31:0] Q_ONE = 32'sd1 <<< Q_FRAC;

  function automatic logic signed [31:0] to_q(input int i);
    return 32'(i) <<< Q_FRAC;
  endfunction

  // Clamp v into the signed w-bit range; result stays sign-extended to 64 bits.
  function automatic logic signed [63:0] saturate(input logic signed [63:0] v,
                                                  input int unsigned w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/verlet_node_q_fxp_sat_add.sv
// Signed 3-input adder with saturation to the W-bit two's complement range.
module fxp_sat_add #(
  parameter int unsigned W = 32
) (
  input  logic signed [W-1:0] i_a,
  input  logic signed [W-1:0] i_b,
  input  logic signed [W-1:0] i_c,
  output logic signed [W-1:0] o_sum
);

  localparam logic signed [W+1:0] MAXV = {3'b000, {(W-1){1'b1}}};
  localparam logic signed [W+1:0] MINV = {3'b111, {(W-1){1'b0}}};

  logic signed [W+1:0] w_sum;

  assign w_sum = $signed({{2{i_a[W-1]}}, i_a})
               + $signed({{2{i_b[W-1]}}, i_b})
               + $signed({{2{i_c[W-1]}}, i_c});

  always_comb begin
    o_sum = w_sum[W-1:0];
    if (w_sum > MAXV)      o_sum = MAXV[W-1:0];
    else if (w_sum < MINV) o_sum = MINV[W-1:0];
  end

endmodule

// File: rtl/verlet_node_q.sv
// Fixed-point Verlet integrator node: one particle, one step per handshake,
// constraint corrections accepted between steps.
module verlet_node_q
  import verlet_pkg::*;
#(
  parameter int unsigned      WIDTH      = 32,
  parameter int unsigned      FRAC       = 16,
  parameter int               NODE_ID    = 1,
  parameter int               BASE_X     = 200,
  parameter int               SPACING    = 10,
  parameter logic [WIDTH-1:0] GRAVITY    = 32'h0000_4CCD,
  parameter int unsigned      DAMP_SHIFT = 0,
  parameter bit               PINNED     = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             step_valid,
  output logic             step_ready,
  input  logic             cons_valid,
  output logic             cons_ready,
  input  logic [WIDTH-1:0] cons_x,
  input  logic [WIDTH-1:0] cons_y,
  output logic [WIDTH-1:0] x_pos,
  output logic [WIDTH-1:0] y_pos,
  output logic             step_done,
  output logic [15:0]      step_count,
  output logic             busy
);

  localparam logic signed [WIDTH-1:0] X_RST = WIDTH'(BASE_X) << FRAC;
  localparam logic signed [WIDTH-1:0] Y_RST = WIDTH'(SPACING * NODE_ID) << FRAC;

  state_t                  r_state;
  logic signed [WIDTH-1:0] r_x, r_y, r_px, r_py, r_vx, r_vy;
  logic                    r_done;
  logic [15:0]             r_count;

  logic signed [WIDTH:0]   w_dx, w_dy, w_dxd, w_dyd;
  logic signed [63:0]      w_vx64, w_vy64;
  logic signed [WIDTH-1:0] w_nx, w_ny;

  // Velocity keeps one guard bit so x-px cannot wrap before damping/saturation.
  assign w_dx = $signed({r_x[WIDTH-1], r_x}) - $signed({r_px[WIDTH-1], r_px});
  assign w_dy = $signed({r_y[WIDTH-1], r_y}) - $signed({r_py[WIDTH-1], r_py});

  if (DAMP_SHIFT > 0) begin : g_damp
    assign w_dxd = w_dx - (w_dx >>> DAMP_SHIFT);
    assign w_dyd = w_dy - (w_dy >>> DAMP_SHIFT);
  end else begin : g_nodamp
    assign w_dxd = w_dx;
    assign w_dyd = w_dy;
  end

  assign w_vx64 = saturate(64'(w_dxd), WIDTH);
  assign w_vy64 = saturate(64'(w_dyd), WIDTH);

  fxp_sat_add #(.W(WIDTH)) u_add_x (
    .i_a  (r_x),
    .i_b  (r_vx),
    .i_c  ('0),
    .o_sum(w_nx)
  );

  fxp_sat_add #(.W(WIDTH)) u_add_y (
    .i_a  (r_y),
    .i_b  (r_vy),
    .i_c  (GRAVITY),
    .o_sum(w_ny)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_x     <= X_RST;
      r_px    <= X_RST;
      r_y     <= Y_RST;
      r_py    <= Y_RST;
      r_vx    <= '0;
      r_vy    <= '0;
      r_done  <= 1'b0;
      r_count <= '0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        IDLE: begin
          // A constraint pre-empts a simultaneous step request.
          if (cons_valid) begin
            if (!PINNED) begin
              r_x <= cons_x;
              r_y <= cons_y;
            end
          end else if (step_valid) begin
            r_state <= VEL;
          end
        end
        VEL: begin
          r_vx    <= w_vx64[WIDTH-1:0];
          r_vy    <= w_vy64[WIDTH-1:0];
          r_state <= POS;
        end
        POS: begin
          if (!PINNED) begin
            r_px <= r_x;
            r_py <= r_y;
            r_x  <= w_nx;
            r_y  <= w_ny;
          end
          r_done  <= 1'b1;
          r_count <= r_count + 16'd1;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign cons_ready = (r_state == IDLE);
  assign step_ready = (r_state == IDLE) && !cons_valid;
  assign busy       = (r_state != IDLE);
  assign x_pos      = r_x;
  assign y_pos      = r_y;
  assign step_done  = r_done;
  assign step_count = r_count;

endmodule
